// File: rtl/csr_pkg.sv
// csr_pkg -- shared definitions for the machine-mode CSR file and trap unit.
//   CSR addresses, csr_op encodings, interrupt cause codes, mstatus bit
//   positions, mtvec mode values and reset constants.
package csr_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;
    localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH = 12'hB80;
    localparam logic [11:0] CSR_MHARTID = 12'hF14;

    // CSR access operation
    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    // mstatus bit positions
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LO   = 11;
    localparam int MSTATUS_MPP_HI   = 12;

    // Interrupt cause codes (also the mip/mie bit index)
    localparam logic [4:0] IRQ_CODE_TIMER     = 5'd7;
    localparam logic [4:0] IRQ_CODE_EXT       = 5'd11;
    localparam logic [4:0] IRQ_CODE_PLAT_BASE = 5'd16;

    // mtvec modes
    localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    // Reset values
    localparam logic [31:0] MIE_RESET = 32'h0000_0800;

endpackage

// File: rtl/csr_irq_prio.sv
// csr_irq_prio -- fixed-priority interrupt selector.
//   pending : mip & mie, indexed by interrupt code
//   valid   : at least one enabled interrupt is pending
//   code    : winning cause code; external > timer > platform (lowest first)
module csr_irq_prio
    import csr_pkg::*;
#(
    parameter int N_PLAT_IRQ = 4
) (
    input  logic [31:0] pending,
    output logic        valid,
    output logic [4:0]  code
);

    localparam logic [31:0] USED_MASK =
        (32'd1 << IRQ_CODE_EXT) | (32'd1 << IRQ_CODE_TIMER) |
        (((32'd1 << N_PLAT_IRQ) - 32'd1) << IRQ_CODE_PLAT_BASE);

    // Bits outside the implemented interrupt set never win.
    logic unused_pending;
    assign unused_pending = |(pending & ~USED_MASK);

    always_comb begin
        valid = 1'b0;
        code  = '0;
        // Scan platform lines from the top down so the lowest index ends up
        // selected, then let timer and external override in rising priority.
        for (int i = N_PLAT_IRQ - 1; i >= 0; i--) begin
            if (pending[int'(IRQ_CODE_PLAT_BASE) + i]) begin
                valid = 1'b1;
                code  = IRQ_CODE_PLAT_BASE + 5'(i);
            end
        end
        if (pending[IRQ_CODE_TIMER]) begin
            valid = 1'b1;
            code  = IRQ_CODE_TIMER;
        end
        if (pending[IRQ_CODE_EXT]) begin
            valid = 1'b1;
            code  = IRQ_CODE_EXT;
        end
    end

endmodule

// File: rtl/csr_regfile_trap.sv
// csr_regfile_trap -- machine-mode CSR register file with trap entry/return.
//   clock, reset            : clock, asynchronous active-high reset
//   csr_addr/we/op/w_data   : CSR access (op: none/write/set/clear)
//   csr_r_data, csr_illegal : combinational read data and access fault
//   pc, exc_req/cause/tval  : current PC and synchronous exception request
//   ret                     : mret executing
//   irq_timer/ext/plat      : interrupt levels, sampled into mip each cycle
//   trap_taken, trap_pc     : trap entry this cycle and redirect target
//   mepc                    : current mepc (mret target)
module csr_regfile_trap
    import csr_pkg::*;
#(
    parameter int          N_PLAT_IRQ  = 4,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0500,
    parameter int unsigned HART_ID     = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [11:0]           csr_addr,
    input  logic                  csr_we,
    input  logic [1:0]            csr_op,
    input  logic [31:0]           csr_w_data,
    output logic [31:0]           csr_r_data,
    output logic                  csr_illegal,
    input  logic [31:0]           pc,
    input  logic                  exc_req,
    input  logic [3:0]            exc_cause,
    input  logic [31:0]           exc_tval,
    input  logic                  ret,
    input  logic                  irq_timer,
    input  logic                  irq_ext,
    input  logic [N_PLAT_IRQ-1:0] irq_plat,
    output logic                  trap_taken,
    output logic [31:0]           trap_pc,
    output logic [31:0]           mepc
);

    localparam logic [31:0] MIE_WMASK =
        (32'd1 << IRQ_CODE_EXT) | (32'd1 << IRQ_CODE_TIMER) |
        (((32'd1 << N_PLAT_IRQ) - 32'd1) << IRQ_CODE_PLAT_BASE);

    // Architectural state
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic [31:0] mie_q;
    logic [31:0] mtvec_q;
    logic [31:2] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;
    logic [31:0] mip_q;
    logic [63:0] mcycle_q;

    csr_op_e     op;
    logic [31:0] mstatus_rd;
    logic [31:0] rd_data;
    logic        addr_hit;
    logic        addr_ro;
    logic        wr_req;
    logic        wr_en;
    logic [31:0] wdata;
    logic [31:0] mip_d;

    logic        irq_valid;
    logic [4:0]  irq_code;
    logic        irq_take;
    logic        ret_take;
    logic [31:0] trap_cause;

    // mepc is word aligned, so the low PC bits are never stored.
    logic unused_pc_lo;
    assign unused_pc_lo = ^pc[1:0];

    assign op = csr_op_e'(csr_op);

    always_comb begin
        mstatus_rd                                = '0;
        mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mstatus_rd[MSTATUS_MPIE_BIT]              = mstatus_mpie;
        mstatus_rd[MSTATUS_MIE_BIT]               = mstatus_mie;
    end

    // Read decode
    always_comb begin
        rd_data  = '0;
        addr_hit = 1'b1;
        addr_ro  = 1'b0;
        case (csr_addr)
            CSR_MSTATUS: rd_data = mstatus_rd;
            CSR_MIE:     rd_data = mie_q;
            CSR_MTVEC:   rd_data = mtvec_q;
            CSR_MEPC:    rd_data = {mepc_q, 2'b00};
            CSR_MCAUSE:  rd_data = mcause_q;
            CSR_MTVAL:   rd_data = mtval_q;
            CSR_MIP: begin
                rd_data = mip_q;
                addr_ro = 1'b1;
            end
            CSR_MCYCLE:  rd_data = mcycle_q[31:0];
            CSR_MCYCLEH: rd_data = mcycle_q[63:32];
            CSR_MHARTID: begin
                rd_data = 32'(HART_ID);
                addr_ro = 1'b1;
            end
            default:     addr_hit = 1'b0;
        endcase
    end

    assign csr_r_data  = rd_data;
    assign wr_req      = csr_we && (op != CSR_OP_NONE);
    assign csr_illegal = !addr_hit || (wr_req && addr_ro);
    assign wr_en       = wr_req && addr_hit && !addr_ro;

    // Read-modify-write operand
    always_comb begin
        wdata = csr_w_data;
        case (op)
            CSR_OP_SET:   wdata = rd_data | csr_w_data;
            CSR_OP_CLEAR: wdata = rd_data & ~csr_w_data;
            default:      wdata = csr_w_data;
        endcase
    end

    // Interrupt selection and trap decision
    csr_irq_prio #(
        .N_PLAT_IRQ (N_PLAT_IRQ)
    ) u_irq_prio (
        .pending (mip_q & mie_q),
        .valid   (irq_valid),
        .code    (irq_code)
    );

    // ret takes precedence over an interrupt; the interrupt is picked up once
    // the restored MIE is visible in the following cycle.
    assign irq_take   = mstatus_mie && irq_valid && !exc_req && !ret;
    assign trap_taken = !reset && (exc_req || irq_take);
    assign ret_take   = !reset && ret && !exc_req;
    assign trap_cause = exc_req ? {28'd0, exc_cause} : {1'b1, 26'd0, irq_code};

    always_comb begin
        trap_pc = {mtvec_q[31:2], 2'b00};
        if (!exc_req && (mtvec_q[1:0] == MTVEC_MODE_VECTORED))
            trap_pc = {mtvec_q[31:2], 2'b00} + {25'd0, irq_code, 2'b00};
    end

    assign mepc = {mepc_q, 2'b00};

    always_comb begin
        mip_d                                       = '0;
        mip_d[IRQ_CODE_TIMER]                       = irq_timer;
        mip_d[IRQ_CODE_EXT]                         = irq_ext;
        mip_d[IRQ_CODE_PLAT_BASE +: N_PLAT_IRQ]     = irq_plat;
    end

    // mstatus: trap and ret outrank a software write
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mstatus_mie  <= 1'b1;
            mstatus_mpie <= 1'b0;
        end else if (trap_taken) begin
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (ret_take) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (wr_en && (csr_addr == CSR_MSTATUS)) begin
            mstatus_mie  <= wdata[MSTATUS_MIE_BIT];
            mstatus_mpie <= wdata[MSTATUS_MPIE_BIT];
        end
    end

    // Trap record registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mepc_q   <= '0;
            mcause_q <= '0;
            mtval_q  <= '0;
        end else if (trap_taken) begin
            mepc_q   <= pc[31:2];
            mcause_q <= trap_cause;
            mtval_q  <= exc_req ? exc_tval : 32'd0;
        end else begin
            if (wr_en && (csr_addr == CSR_MEPC))   mepc_q   <= wdata[31:2];
            if (wr_en && (csr_addr == CSR_MCAUSE)) mcause_q <= wdata;
            if (wr_en && (csr_addr == CSR_MTVAL))  mtval_q  <= wdata;
        end
    end

    // mie / mtvec; reserved mtvec modes collapse to direct
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mie_q   <= MIE_RESET;
            mtvec_q <= MTVEC_RESET;
        end else begin
            if (wr_en && (csr_addr == CSR_MIE))
                mie_q <= wdata & MIE_WMASK;
            if (wr_en && (csr_addr == CSR_MTVEC))
                mtvec_q <= {wdata[31:2], (wdata[1:0] == MTVEC_MODE_VECTORED) ?
                                         MTVEC_MODE_VECTORED : MTVEC_MODE_DIRECT};
        end
    end

    // mip samples the interrupt levels every cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) mip_q <= '0;
        else       mip_q <= mip_d;
    end

    // mcycle: a write to either half replaces it and skips that cycle's count
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            mcycle_q <= '0;
        else if (wr_en && (csr_addr == CSR_MCYCLE))
            mcycle_q[31:0] <= wdata;
        else if (wr_en && (csr_addr == CSR_MCYCLEH))
            mcycle_q[63:32] <= wdata;
        else
            mcycle_q <= mcycle_q + 64'd1;
    end

endmodule

// File: doc/csr_regfile_trap.md
CSR_REGFILE_TRAP -- requirements
Module: csr_regfile_trap

Interface
REQ-001 SHALL have parameter N_PLAT_IRQ, default 4, meaning platform interrupt lines mapped to mip/mie bits 16..16+N_PLAT_IRQ-1 (range 1..16).
REQ-002 SHALL have parameter MTVEC_RESET, default 32'h00000500, meaning the mtvec reset value.
REQ-003 SHALL have parameter HART_ID, default 0, meaning the mhartid read value.
REQ-004 SHALL have the following ports, one per line: name, direction, width, meaning.
  clock  in  1  single clock; all state updates on the rising edge.
  reset  in  1  asynchronous, active-high reset.
  csr_addr  in  12  CSR address.
  csr_we  in  1  CSR access with write intent.
  csr_op  in  2  00 none, 01 write, 10 set, 11 clear.
  csr_w_data  in  32  write operand.
  csr_r_data  out  32  combinational read data.
  csr_illegal  out  1  unmapped address, or write to read-only CSR.
  pc  in  32  PC of the current instruction.
  exc_req  in  1  synchronous exception request.
  exc_cause  in  4  exception code.
  exc_tval  in  32  exception trap value.
  ret  in  1  mret executing.
  irq_timer  in  1  timer interrupt level.
  irq_ext  in  1  external interrupt level.
  irq_plat  in  N_PLAT_IRQ  platform interrupt levels.
  trap_taken  out  1  combinational pulse; trap is entered this cycle.
  trap_pc  out  32  redirect target, valid when trap_taken.
  mepc  out  32  current mepc, used as the mret target.

Function
REQ-005 SHALL decode mstatus 300, mie 304, mtvec 305, mepc 341, mcause 342, mtval 343, mip 344, mcycle B00, mcycleh B80, and mhartid F14 (read-only).
REQ-006 SHALL return 0 with csr_illegal=1 for unmapped reads; mepc bits [1:0] SHALL read 0.
REQ-007 SHALL compute the write value as W, old|W, or old&~W for op 01, 10, or 11 when csr_we=1, and SHALL commit it on the next edge.
REQ-008 SHALL treat op 00 as no write, and SHALL leave state unchanged with csr_illegal=1 on a write to mhartid or mip.
REQ-009 SHALL make only mstatus bits MIE[3] and MPIE[7] writable; MPP[12:11] SHALL read 11.
REQ-010 SHALL make only mie bits 7, 11, and 16..16+N_PLAT_IRQ-1 writable.
REQ-011 SHALL store mtvec mode values 10 and 11 as 00; mode 01 is vectored.
REQ-012 SHALL register mip every cycle (1-cycle latency): bit7=irq_timer, bit11=irq_ext, bit16+i=irq_plat[i].
REQ-013 SHALL define pending = mip & mie, and SHALL request an interrupt when mstatus.MIE=1 and pending!=0.
REQ-014 SHALL prioritise exc_req > ret > interrupt; an interrupt coinciding with ret SHALL be deferred until the cycle after MIE is restored.
REQ-015 SHALL prioritise interrupts as bit 11 > bit 7 > platform bits, lowest index first.
REQ-016 SHALL, on trap entry, assert trap_taken in the same cycle and at the edge load: mepc<=pc; mcause<={interrupt flag, code}; mtval<=exc_tval for exceptions or 0 for interrupts; MPIE<=MIE; MIE<=0.
REQ-017 SHALL set trap_pc = {mtvec[31:2],00}, plus 4*code for interrupts in vectored mode.
REQ-018 SHALL, on ret, set MIE<=MPIE and MPIE<=1.
REQ-019 SHALL let trap or ret updates override a same-cycle CSR write to mstatus, mepc, mcause, or mtval; writes to other CSRs SHALL proceed.
REQ-020 SHALL increment the 64-bit mcycle every cycle with wrap-around.
REQ-021 SHALL, on a mcycle or mcycleh write, replace that half and suppress the increment in that cycle.

Reset
REQ-022 SHALL, while reset=1 and independent of clock, set mstatus=0x00001808, mie=0x00000800, mtvec=MTVEC_RESET, mepc/mcause/mtval/mip/mcycle=0; trap_taken SHALL be 0 during reset.
REQ-023 SHALL drop any trap or write in progress when reset asserts mid-operation, and SHALL record no partial state.

Structure
REQ-024 SHALL place CSR addresses, csr_op encodings, cause codes, and mstatus bit indices in shared package csr_pkg.
REQ-025 SHALL implement interrupt selection in sub-module csr_irq_prio (pending vector in; valid and code out).

Verification
REQ-026 Reset then read 300/304/305 -> 0x00001808, 0x00000800, 0x00000500; read 7C0 -> 0 with csr_illegal=1.
REQ-027 Write 0xFFFFFFFF to mie, then clear 0x80 -> mie reads 0x000F0800 (N_PLAT_IRQ=4).
REQ-028 irq_ext=1 with pc=0x100 -> trap_taken one cycle after mip sets; mepc=0x100, mcause=0x8000000B, mstatus=0x00001880, trap_pc=0x500.
REQ-029 mtvec=0x501 with irq_plat[2] and irq_timer both pending -> timer wins, trap_pc=0x51C; after ret and MIE restored, plat2 is taken with mcause=0x80000012.
REQ-030 exc_req with cause 2, tval 0xDEAD, ret, and a pending interrupt in the same cycle -> exception is taken with mcause=2 and mtval=0xDEAD.
REQ-031 Write mcycle=0xFFFFFFFF and mcycleh=0 -> two cycles later mcycleh=1 and mcycle=1; reset asserted mid-count -> mcycle=0 immediately.
